// File: rtl/datapath_ctrl.sv
// Multi-cycle sequencer for the 64-bit datapath. It accepts one instruction over a valid/ready
// handshake, then drives a registered control word through the EXEC, MEMA and MEMD phases.
module datapath_ctrl #(
  parameter int DATA_W   = 64,
  parameter int IMM_W    = 13,
  parameter int MEM_WAIT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_instr_valid,
  input  logic [31:0]       i_instr,
  output logic              o_instr_ready,
  output logic              o_done,
  output logic              o_illegal,
  output logic [4:0]        o_reg_addr,
  output logic [4:0]        o_a_addr,
  output logic [4:0]        o_b_addr,
  output logic [4:0]        o_fs,
  output logic [DATA_W-1:0] o_k,
  output logic              o_reg_w,
  output logic              o_b_sel,
  output logic              o_b_en,
  output logic              o_alu_en,
  output logic              o_mem_en,
  output logic              o_chip_sel,
  output logic              o_mem_w,
  output logic              o_mem_r,
  output logic              o_stat_en,
  output logic              o_c0
);

  localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT - 1);

  localparam logic [3:0] OP_AND = 4'h0, OP_ORR = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3;
  localparam logic [3:0] OP_EOR = 4'h4, OP_LSL = 4'h5, OP_LSR = 4'h6, OP_ADDI = 4'h7;
  localparam logic [3:0] OP_ANDI = 4'h8, OP_ORRI = 4'h9, OP_LDUR = 4'hA, OP_STUR = 4'hB;
  localparam logic [3:0] OP_MOVI = 4'hC, OP_CMP = 4'hD;

  localparam logic [4:0] FS_AND = 5'b00000, FS_ORR = 5'b00100, FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001, FS_EOR = 5'b01100, FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  typedef enum logic [1:0] {IDLE, EXEC, MEMA, MEMD} stateT;

  typedef struct packed {
    logic              ready;
    logic              done;
    logic              illegal;
    logic [4:0]        regAddr;
    logic [4:0]        aAddr;
    logic [4:0]        bAddr;
    logic [4:0]        fs;
    logic [DATA_W-1:0] k;
    logic              regW;
    logic              bSel;
    logic              bEn;
    logic              aluEn;
    logic              memEn;
    logic              chipSel;
    logic              memW;
    logic              memR;
    logic              statEn;
    logic              c0;
  } ctrlT;

  stateT             r_state, w_nextState;
  logic [CNT_W-1:0]  r_waitCnt, w_nextCnt;
  logic [31:0]       r_instr, w_cur;
  ctrlT              r_ctrl, w_ctrl;
  logic              w_accept, w_wrEn;
  logic [3:0]        w_op;
  logic [4:0]        w_rd, w_rn, w_rm;
  logic [DATA_W-1:0] w_imm;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_waitCnt  <= '0;
      r_instr    <= '0;
      r_ctrl     <= '0;
      r_ctrl.fs  <= FS_ADD;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextCnt;
      r_ctrl    <= w_ctrl;
      if (w_accept) r_instr <= i_instr;
    end
  end

  // The control word is computed for the state being entered, so every output is a flop.
  always_comb begin
    w_accept    = r_ctrl.ready & i_instr_valid;
    w_cur       = w_accept ? i_instr : r_instr;
    w_op        = w_cur[31:28];
    w_rd        = w_cur[27:23];
    w_rn        = w_cur[22:18];
    w_rm        = w_cur[17:13];
    w_imm       = DATA_W'(w_cur[IMM_W-1:0]);
    w_wrEn      = (w_rd != 5'd31);
    w_nextState = r_state;
    w_nextCnt   = '0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_op == OP_LDUR || w_op == OP_STUR) w_nextState = MEMA;
          else if (w_op == 4'hE || w_op == 4'hF)  w_nextState = IDLE;
          else                                    w_nextState = EXEC;
        end
      end
      EXEC: w_nextState = IDLE;
      MEMA: begin
        if (r_waitCnt == CNT_LAST) w_nextState = (w_op == OP_LDUR) ? MEMD : IDLE;
        else                       w_nextCnt   = r_waitCnt + CNT_W'(1);
      end
      MEMD: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase

    w_ctrl         = '0;
    w_ctrl.fs      = FS_ADD;
    w_ctrl.ready   = (w_nextState == IDLE);
    w_ctrl.illegal = w_accept && (w_op == 4'hE || w_op == 4'hF);

    case (w_nextState)
      EXEC: begin
        w_ctrl.aAddr   = (w_op == OP_MOVI) ? 5'd31 : w_rn;
        w_ctrl.bAddr   = w_rm;
        w_ctrl.regAddr = w_rd;
        w_ctrl.aluEn   = 1'b1;
        w_ctrl.done    = 1'b1;
        w_ctrl.regW    = (w_op != OP_CMP) && w_wrEn;
        w_ctrl.c0      = (w_op == OP_SUB) || (w_op == OP_CMP);
        w_ctrl.statEn  = (w_op == OP_CMP);
        w_ctrl.bSel    = (w_op == OP_ADDI) || (w_op == OP_ANDI) ||
                         (w_op == OP_ORRI) || (w_op == OP_MOVI);
        w_ctrl.k       = w_ctrl.bSel ? w_imm : '0;
        case (w_op)
          OP_AND, OP_ANDI:         w_ctrl.fs = FS_AND;
          OP_ORR, OP_ORRI, OP_MOVI: w_ctrl.fs = FS_ORR;
          OP_SUB, OP_CMP:          w_ctrl.fs = FS_SUB;
          OP_EOR:                  w_ctrl.fs = FS_EOR;
          OP_LSL:                  w_ctrl.fs = FS_LSL;
          OP_LSR:                  w_ctrl.fs = FS_LSR;
          default:                 w_ctrl.fs = FS_ADD;
        endcase
      end
      MEMA: begin
        w_ctrl.aAddr   = w_rn;
        w_ctrl.bSel    = 1'b1;
        w_ctrl.k       = w_imm;
        w_ctrl.chipSel = 1'b1;
        if (w_op == OP_LDUR) begin
          w_ctrl.memR = 1'b1;
        end else begin
          // Store data rides on B; the write strobe fires once, on the last address cycle.
          w_ctrl.bAddr = w_rd;
          w_ctrl.bEn   = 1'b1;
          w_ctrl.memW  = (w_nextCnt == CNT_LAST);
          w_ctrl.done  = (w_nextCnt == CNT_LAST);
        end
      end
      MEMD: begin
        w_ctrl.chipSel = 1'b1;
        w_ctrl.memR    = 1'b1;
        w_ctrl.memEn   = 1'b1;
        w_ctrl.regW    = w_wrEn;
        w_ctrl.regAddr = w_rd;
        w_ctrl.done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_instr_ready = r_ctrl.ready;
  assign o_done        = r_ctrl.done;
  assign o_illegal     = r_ctrl.illegal;
  assign o_reg_addr    = r_ctrl.regAddr;
  assign o_a_addr      = r_ctrl.aAddr;
  assign o_b_addr      = r_ctrl.bAddr;
  assign o_fs          = r_ctrl.fs;
  assign o_k           = r_ctrl.k;
  assign o_reg_w       = r_ctrl.regW;
  assign o_b_sel       = r_ctrl.bSel;
  assign o_b_en        = r_ctrl.bEn;
  assign o_alu_en      = r_ctrl.aluEn;
  assign o_mem_en      = r_ctrl.memEn;
  assign o_chip_sel    = r_ctrl.chipSel;
  assign o_mem_w       = r_ctrl.memW;
  assign o_mem_r       = r_ctrl.memR;
  assign o_stat_en     = r_ctrl.statEn;
  assign o_c0          = r_ctrl.c0;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for datapath_ctrl (MEM_WAIT=2): drives single instructions and compares the
// control word cycle by cycle against hand-computed values.
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instrValid;
  logic [31:0] instr;
  logic        instrReady, done, illegal;
  logic [4:0]  regAddr, aAddr, bAddr, fs;
  logic [63:0] k;
  logic        regW, bSel, bEn, aluEn, memEn, chipSel, memW, memR, statEn, c0;
  logic [9:0]  ctrlBits;

  int checkCount = 0;
  int errorCount = 0;

  datapath_ctrl #(.DATA_W(64), .IMM_W(13), .MEM_WAIT(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_instr_valid(instrValid), .i_instr(instr),
    .o_instr_ready(instrReady), .o_done(done), .o_illegal(illegal),
    .o_reg_addr(regAddr), .o_a_addr(aAddr), .o_b_addr(bAddr), .o_fs(fs), .o_k(k),
    .o_reg_w(regW), .o_b_sel(bSel), .o_b_en(bEn), .o_alu_en(aluEn), .o_mem_en(memEn),
    .o_chip_sel(chipSel), .o_mem_w(memW), .o_mem_r(memR), .o_stat_en(statEn), .o_c0(c0)
  );

  always #5 clk = ~clk;

  // Bit order: regW bSel bEn aluEn memEn chipSel memW memR statEn c0
  assign ctrlBits = {regW, bSel, bEn, aluEn, memEn, chipSel, memW, memR, statEn, c0};

  function automatic logic [31:0] mkInstr(input logic [3:0] op, input logic [4:0] rd,
                                          input logic [4:0] rn, input logic [4:0] rm,
                                          input logic [12:0] imm);
    return {op, rd, rn, rm, imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Offers one instruction for a single edge; returns at the first execution cycle.
  task automatic applyStimulus(input logic [31:0] word);
    @(negedge clk);
    instrValid = 1'b1;
    instr      = word;
    @(negedge clk);
    instrValid = 1'b0;
  endtask

  int memWCount;
  int doneCount;

  initial begin
    rst = 1'b1; instrValid = 1'b0; instr = '0;
    repeat (2) @(negedge clk);
    checkOutput("rstCtrl", 64'(ctrlBits), 64'h0);
    checkOutput("rstFs", 64'(fs), 64'b01000);
    checkOutput("rstK", k, 64'h0);
    checkOutput("rstDone", 64'({done, illegal}), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstReady", 64'(instrReady), 64'h1);

    // Reset held three cycles in the middle of a load
    applyStimulus(mkInstr(4'hA, 5'd4, 5'd2, 5'd0, 13'd8));
    checkOutput("midLdurMemA", 64'(ctrlBits), 64'(10'b0100010100));
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("midRstCtrl", 64'(ctrlBits), 64'h0);
      checkOutput("midRstFs", 64'(fs), 64'b01000);
      checkOutput("midRstDone", 64'(done), 64'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstReady", 64'(instrReady), 64'h1);
    checkOutput("midRstIdle", 64'(ctrlBits), 64'h0);

    // MOVI rd=0 imm=2
    applyStimulus(mkInstr(4'hC, 5'd0, 5'd7, 5'd9, 13'd2));
    checkOutput("moviCtrl", 64'(ctrlBits), 64'(10'b1101000000));
    checkOutput("moviAAddr", 64'(aAddr), 64'd31);
    checkOutput("moviK", k, 64'd2);
    checkOutput("moviFs", 64'(fs), 64'b00100);
    checkOutput("moviRegAddr", 64'(regAddr), 64'd0);
    checkOutput("moviDone", 64'({done, instrReady}), 64'b10);
    @(negedge clk);
    checkOutput("moviAfter", 64'({done, instrReady, ctrlBits}), 64'(12'b010000000000));

    // SUB rd=5 rn=0 rm=1, then CMP with the same registers
    applyStimulus(mkInstr(4'h3, 5'd5, 5'd0, 5'd1, 13'd0));
    checkOutput("subCtrl", 64'(ctrlBits), 64'(10'b1001000001));
    checkOutput("subFs", 64'(fs), 64'b01001);
    checkOutput("subAddrs", 64'({regAddr, aAddr, bAddr}), 64'({5'd5, 5'd0, 5'd1}));
    checkOutput("subDone", 64'(done), 64'h1);
    @(negedge clk);
    applyStimulus(mkInstr(4'hD, 5'd5, 5'd0, 5'd1, 13'd0));
    checkOutput("cmpCtrl", 64'(ctrlBits), 64'(10'b0001000011));
    checkOutput("cmpFs", 64'(fs), 64'b01001);
    checkOutput("cmpDone", 64'(done), 64'h1);
    @(negedge clk);

    // LDUR rd=4 rn=2 imm=8: two address cycles then the data cycle
    applyStimulus(mkInstr(4'hA, 5'd4, 5'd2, 5'd0, 13'd8));
    for (int i = 0; i < 2; i++) begin
      checkOutput("ldurMemACtrl", 64'(ctrlBits), 64'(10'b0100010100));
      checkOutput("ldurMemAK", k, 64'd8);
      checkOutput("ldurMemAAddr", 64'({aAddr, fs}), 64'({5'd2, 5'b01000}));
      checkOutput("ldurMemADone", 64'({done, instrReady}), 64'h0);
      @(negedge clk);
    end
    checkOutput("ldurMemDCtrl", 64'(ctrlBits), 64'(10'b1000110100));
    checkOutput("ldurMemDReg", 64'(regAddr), 64'd4);
    checkOutput("ldurMemDDone", 64'(done), 64'h1);
    @(negedge clk);
    checkOutput("ldurAfter", 64'({done, instrReady, ctrlBits}), 64'(12'b010000000000));

    // STUR rd=3 rn=2 imm=0: one write strobe on the second address cycle
    memWCount = 0;
    applyStimulus(mkInstr(4'hB, 5'd3, 5'd2, 5'd0, 13'd0));
    checkOutput("sturCyc1", 64'({done, ctrlBits}), 64'(11'b00110010000));
    checkOutput("sturBAddr1", 64'(bAddr), 64'd3);
    memWCount += int'(memW);
    @(negedge clk);
    checkOutput("sturCyc2", 64'({done, ctrlBits}), 64'(11'b10110011000));
    checkOutput("sturBAddr2", 64'(bAddr), 64'd3);
    memWCount += int'(memW);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      memWCount += int'(memW);
    end
    checkOutput("sturMemWCount", 64'(memWCount), 64'd1);
    checkOutput("sturAfterReady", 64'(instrReady), 64'h1);

    // Illegal opcode: pulse only, no controls
    applyStimulus(mkInstr(4'hF, 5'd1, 5'd2, 5'd3, 13'd5));
    checkOutput("illegalPulse", 64'({illegal, done, instrReady}), 64'b101);
    checkOutput("illegalCtrl", 64'(ctrlBits), 64'h0);
    @(negedge clk);
    checkOutput("illegalAfter", 64'(illegal), 64'h0);

    // ADD into XZR
    applyStimulus(mkInstr(4'h2, 5'd31, 5'd1, 5'd2, 13'd0));
    checkOutput("addXzrCtrl", 64'(ctrlBits), 64'(10'b0001000000));
    checkOutput("addXzrDone", 64'(done), 64'h1);
    @(negedge clk);

    // Valid held through a busy LDUR must produce exactly one accept
    doneCount = 0;
    instrValid = 1'b1;
    instr      = mkInstr(4'hA, 5'd6, 5'd1, 5'd0, 13'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      doneCount += int'(done);
    end
    instrValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      doneCount += int'(done);
    end
    checkOutput("heldValidDones", 64'(doneCount), 64'd1);
    checkOutput("heldValidIdle", 64'({instrReady, ctrlBits}), 64'(11'b10000000000));

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
